// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match controller.
package pong_pkg;

    localparam int unsigned ScoreW        = 4;
    localparam int unsigned DefWinScore   = 7;
    localparam int unsigned DefPointDelay = 60;
    localparam int unsigned DelayW        = 8;

    typedef logic [ScoreW-1:0] score_t;
    typedef logic [DelayW-1:0] delay_t;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPoint,
        StPaused,
        StOver
    } state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button or switch, with optional 1->0 pulse output.
module btn_sync #(
    parameter logic ResetVal = 1'b0,
    parameter bit   PulseOut = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic out_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            prev_q <= ResetVal;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Pulse mode emits one cycle on the synchronised falling edge; level mode passes sync_q.
    assign out_o = PulseOut ? (prev_q & ~sync_q) : sync_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve/play/point/pause/game-over sequencing and score keeping.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DefWinScore,
    parameter int unsigned POINT_DELAY = DefPointDelay
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              serve_n,
    input  logic              pause,
    input  logic              miss_left,
    input  logic              miss_right,
    output logic              ball_run,
    output logic              ball_centre,
    output logic              serve_dir,
    output logic [ScoreW-1:0] score0,
    output logic [ScoreW-1:0] score1,
    output logic              game_over,
    output logic              winner
);

    localparam score_t WinScore   = score_t'(WIN_SCORE);
    localparam delay_t PointDelay = delay_t'(POINT_DELAY);

    logic   vsync_q, frame_tick, serve_press, pause_lvl;
    state_e state_q, state_d;
    score_t score0_q, score0_d, score1_q, score1_d;
    delay_t delay_q, delay_d;
    logic   dir_q, dir_d, run_q, run_d, centre_q, centre_d;
    logic   over_q, over_d, win_q, win_d;

    btn_sync #(.ResetVal(1'b1), .PulseOut(1'b1)) u_serve_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .async_i(serve_n),
        .out_o  (serve_press)
    );

    btn_sync #(.ResetVal(1'b0), .PulseOut(1'b0)) u_pause_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .async_i(pause),
        .out_o  (pause_lvl)
    );

    assign frame_tick = vsync_q & ~vsync;

    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        delay_d  = delay_q;
        dir_d    = dir_q;
        run_d    = run_q;
        centre_d = centre_q;
        over_d   = over_q;
        win_d    = win_q;
        unique case (state_q)
            StIdle: begin
                if (serve_press) begin
                    state_d  = StServe;
                    score0_d = '0;
                    score1_d = '0;
                    dir_d    = ~dir_q;
                end
            end
            StServe: begin
                if (serve_press) begin
                    state_d  = StPlay;
                    run_d    = 1'b1;
                    centre_d = 1'b0;
                end
            end
            StPlay: begin
                if (miss_left || miss_right) begin
                    state_d  = StPoint;
                    run_d    = 1'b0;
                    centre_d = 1'b1;
                    delay_d  = PointDelay;
                    // A simultaneous double miss is a replay: no score, direction kept.
                    if (miss_left && !miss_right) begin
                        if (score1_q < WinScore) score1_d = score1_q + score_t'(1);
                        dir_d = 1'b0;
                    end else if (miss_right && !miss_left) begin
                        if (score0_q < WinScore) score0_d = score0_q + score_t'(1);
                        dir_d = 1'b1;
                    end
                end else if (pause_lvl) begin
                    state_d  = StPaused;
                    run_d    = 1'b0;
                    centre_d = 1'b0;
                end
            end
            StPaused: begin
                if (!pause_lvl) begin
                    state_d = StPlay;
                    run_d   = 1'b1;
                end
            end
            StPoint: begin
                if (delay_q == '0) begin
                    if (score0_q == WinScore || score1_q == WinScore) begin
                        state_d = StOver;
                        over_d  = 1'b1;
                        win_d   = (score1_q == WinScore);
                    end else begin
                        state_d = StServe;
                    end
                end else if (frame_tick) begin
                    delay_d = delay_q - delay_t'(1);
                end
            end
            StOver: begin
                if (serve_press) begin
                    state_d  = StIdle;
                    over_d   = 1'b0;
                    win_d    = 1'b0;
                    centre_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q  <= 1'b1;
            state_q  <= StIdle;
            score0_q <= '0;
            score1_q <= '0;
            delay_q  <= '0;
            dir_q    <= 1'b0;
            run_q    <= 1'b0;
            centre_q <= 1'b1;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            state_q  <= state_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            delay_q  <= delay_d;
            dir_q    <= dir_d;
            run_q    <= run_d;
            centre_q <= centre_d;
            over_q   <= over_d;
            win_q    <= win_d;
        end
    end

    assign ball_run    = run_q;
    assign ball_centre = centre_q;
    assign serve_dir   = dir_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign game_over   = over_q;
    assign winner      = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, directed corner cases, random vs model.
module tb_pong_game_ctrl;

    localparam int WIN = 7;
    localparam int DLY = 60;

    localparam int A_NONE   = 0;
    localparam int A_PRESS  = 1;
    localparam int A_ML     = 2;
    localparam int A_MR     = 3;
    localparam int A_BOTH   = 4;
    localparam int A_PAUSE  = 5;
    localparam int A_FRAMES = 6;

    logic       clk = 1'b0;
    logic       reset, vsync, serve_n, pause, miss_left, miss_right;
    logic       ball_run, ball_centre, serve_dir, game_over, winner;
    logic [3:0] score0, score1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int act;
        int arg;
        int run;
        int centre;
        int dir;
        int s0;
        int s1;
        int over;
        int win;
    } vec_t;

    vec_t vecs[15];

    // Reference model state, expressed as game rules rather than RTL registers.
    string m_phase;
    int    m_s0, m_s1, m_left, m_dir, m_over, m_win, m_pause;

    pong_game_ctrl #(.WIN_SCORE(WIN), .POINT_DELAY(DLY)) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .serve_n    (serve_n),
        .pause      (pause),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_run   (ball_run),
        .ball_centre(ball_centre),
        .serve_dir  (serve_dir),
        .score0     (score0),
        .score1     (score1),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int run, input int centre, input int dir,
                             input int s0, input int s1, input int over, input int win);
        check({tag, ".ball_run"}, int'(ball_run), run);
        check({tag, ".ball_centre"}, int'(ball_centre), centre);
        check({tag, ".serve_dir"}, int'(serve_dir), dir);
        check({tag, ".score0"}, int'(score0), s0);
        check({tag, ".score1"}, int'(score1), s1);
        check({tag, ".game_over"}, int'(game_over), over);
        check({tag, ".winner"}, int'(winner), win);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        vsync      = 1'b1;
        serve_n    = 1'b1;
        pause      = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic press();
        serve_n = 1'b0;
        repeat (4) tick();
        serve_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vsync = 1'b0;
            repeat (2) tick();
            vsync = 1'b1;
            repeat (2) tick();
        end
        repeat (3) tick();
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_pause(input int v);
        pause = (v != 0);
        repeat (5) tick();
    endtask

    task automatic apply(input int act, input int arg);
        case (act)
            A_PRESS:  press();
            A_ML:     miss(1'b1, 1'b0);
            A_MR:     miss(1'b0, 1'b1);
            A_BOTH:   miss(1'b1, 1'b1);
            A_PAUSE:  set_pause(arg);
            A_FRAMES: frames(arg);
            default:  tick();
        endcase
    endtask

    task automatic model_settle_pause();
        if (m_phase == "play" && m_pause != 0) m_phase = "paused";
        else if (m_phase == "paused" && m_pause == 0) m_phase = "play";
    endtask

    task automatic model(input int act, input int arg);
        case (act)
            A_PRESS: begin
                if (m_phase == "idle") begin
                    m_phase = "serve";
                    m_s0 = 0;
                    m_s1 = 0;
                    m_dir = 1 - m_dir;
                end else if (m_phase == "serve") begin
                    m_phase = "play";
                end else if (m_phase == "over") begin
                    m_phase = "idle";
                    m_over = 0;
                    m_win = 0;
                end
            end
            A_ML, A_MR, A_BOTH: begin
                if (m_phase == "play") begin
                    if (act == A_ML) begin
                        m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
                        m_dir = 0;
                    end else if (act == A_MR) begin
                        m_s0 = (m_s0 + 1 > WIN) ? WIN : m_s0 + 1;
                        m_dir = 1;
                    end
                    m_phase = "point";
                    m_left = DLY;
                end
            end
            A_PAUSE: m_pause = arg;
            A_FRAMES: begin
                if (m_phase == "point") begin
                    m_left -= arg;
                    if (m_left <= 0) begin
                        if (m_s0 == WIN || m_s1 == WIN) begin
                            m_phase = "over";
                            m_over = 1;
                            m_win = (m_s1 == WIN) ? 1 : 0;
                        end else begin
                            m_phase = "serve";
                        end
                    end
                end
            end
            default: ;
        endcase
        model_settle_pause();
    endtask

    initial begin
        int n;
        int act, arg, r;

        vecs[0]  = '{A_NONE,    0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{A_PRESS,   0, 0, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{A_PRESS,   0, 1, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{A_MR,      0, 0, 1, 1, 1, 0, 0, 0};
        vecs[4]  = '{A_FRAMES, 60, 0, 1, 1, 1, 0, 0, 0};
        vecs[5]  = '{A_PRESS,   0, 1, 0, 1, 1, 0, 0, 0};
        vecs[6]  = '{A_BOTH,    0, 0, 1, 1, 1, 0, 0, 0};
        vecs[7]  = '{A_FRAMES, 60, 0, 1, 1, 1, 0, 0, 0};
        vecs[8]  = '{A_PRESS,   0, 1, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{A_PAUSE,   1, 0, 0, 1, 1, 0, 0, 0};
        vecs[10] = '{A_ML,      0, 0, 0, 1, 1, 0, 0, 0};
        vecs[11] = '{A_PAUSE,   0, 1, 0, 1, 1, 0, 0, 0};
        vecs[12] = '{A_ML,      0, 0, 1, 0, 1, 1, 0, 0};
        vecs[13] = '{A_FRAMES, 60, 0, 1, 0, 1, 1, 0, 0};
        vecs[14] = '{A_PRESS,   0, 1, 0, 0, 1, 1, 0, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].act, vecs[i].arg);
            check_all($sformatf("vec%0d", i), vecs[i].run, vecs[i].centre, vecs[i].dir,
                      vecs[i].s0, vecs[i].s1, vecs[i].over, vecs[i].win);
        end

        // Serve latency from the second press, bounded wait.
        do_reset();
        press();
        serve_n = 1'b0;
        n = 0;
        while (!ball_run && n < 10) begin
            tick();
            n++;
        end
        check("serve_latency_run", int'(ball_run), 1);
        check("serve_latency_ok", (n <= 6) ? 1 : 0, 1);
        serve_n = 1'b1;
        repeat (4) tick();

        // Miss pulse effect on the very next cycle, then exact point delay.
        miss_right = 1'b1;
        tick();
        miss_right = 1'b0;
        check("mr_next_run", int'(ball_run), 0);
        check("mr_next_score0", int'(score0), 1);
        check("mr_next_dir", int'(serve_dir), 1);
        frames(59);
        press();
        check("point_held_59", int'(ball_run), 0);
        frames(1);
        press();
        check("serve_after_60", int'(ball_run), 1);

        // Play to a player-1 win and check saturation after game over.
        do_reset();
        press();
        for (int i = 1; i <= WIN; i++) begin
            press();
            miss(1'b1, 1'b0);
            check($sformatf("win_run.score1_%0d", i), int'(score1), i);
            frames(DLY);
        end
        check("win.game_over", int'(game_over), 1);
        check("win.winner", int'(winner), 1);
        miss(1'b1, 1'b0);
        check("win.score1_held", int'(score1), WIN);
        press();
        check("over_to_idle.game_over", int'(game_over), 0);
        press();
        check("new_match.score1", int'(score1), 0);

        // Asynchronous reset while a point delay is pending.
        do_reset();
        press();
        press();
        miss(1'b0, 1'b1);
        frames(10);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        press();
        press();
        check("after_rst.run", int'(ball_run), 1);
        check("after_rst.score0", int'(score0), 0);

        // Random actions against the rules model.
        do_reset();
        m_phase = "idle";
        m_s0 = 0;
        m_s1 = 0;
        m_left = 0;
        m_dir = 0;
        m_over = 0;
        m_win = 0;
        m_pause = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            arg = 0;
            if (r < 30) act = A_PRESS;
            else if (r < 42) act = A_ML;
            else if (r < 54) act = A_MR;
            else if (r < 58) act = A_BOTH;
            else if (r < 66) begin
                act = A_PAUSE;
                arg = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end else begin
                act = A_FRAMES;
                arg = $urandom_range(1, 40);
            end
            apply(act, arg);
            model(act, arg);
            check_all($sformatf("rnd%0d", i), (m_phase == "play") ? 1 : 0,
                      (m_phase == "play" || m_phase == "paused") ? 0 : 1,
                      m_dir, m_s0, m_s1, m_over, m_win);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
